// File: rtl/accum_drain_ctrl.sv
// Drains accumulator rows through a skewed read port, de-skews the lanes and
// hands whole rows downstream under valid/ready flow control.
//   state | meaning
//   IDLE  | waiting for start_i, no reads
//   SWEEP | issuing read addresses base..base+N+DIM-2, filling the deskew pipe
//   TAIL  | reads finished, holding the final row until accepted
module accum_drain_ctrl #(
  parameter int DIM    = 32,
  parameter int ADDR_W = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic [ADDR_W-1:0]     row_count_i,
  output logic                  acc_rd_en_o,
  output logic                  acc_add_o,
  output logic [ADDR_W-1:0]     acc_addr_rd_o,
  input  logic [DIM-1:0][31:0]  acc_data_i,
  output logic [DIM-1:0][31:0]  row_data_o,
  output logic [ADDR_W-1:0]     row_idx_o,
  output logic                  row_valid_o,
  input  logic                  row_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int KW = ADDR_W + $clog2(DIM) + 1;

  typedef enum logic [1:0] {IDLE, SWEEP, TAIL} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, cnt_q, out_cnt_q;
  logic [KW-1:0]     k_q;
  logic [DIM-1:0]    vld_q;
  logic              done_q, done_d;
  logic              advance, accept, k_last, shift_en;

  assign advance  = !(row_valid_o && !row_ready_i);
  assign accept   = row_valid_o && row_ready_i;
  assign k_last   = (k_q == (KW'(cnt_q) + KW'(DIM - 2)));
  assign shift_en = (state_q == SWEEP) && advance;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (row_count_i == '0) done_d = 1'b1;
          else                   state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (advance && k_last) state_d = TAIL;
      end
      TAIL: begin
        if (accept) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      base_q    <= '0;
      cnt_q     <= '0;
      out_cnt_q <= '0;
      k_q       <= '0;
      vld_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (state_q == IDLE && start_i) begin
        base_q    <= base_addr_i;
        cnt_q     <= row_count_i;
        out_cnt_q <= '0;
      end else if (accept) begin
        out_cnt_q <= out_cnt_q + ADDR_W'(1);
      end
      if (state_q == IDLE)  k_q <= '0;
      else if (shift_en)    k_q <= k_q + KW'(1);
      // Each issued address tags the row it completes DIM-1 edges later.
      if (shift_en)
        vld_q <= {vld_q[DIM-2:0], (k_q < KW'(cnt_q))};
      else if (state_q != SWEEP && accept)
        vld_q <= '0;
    end
  end

  for (genvar c = 0; c < DIM; c++) begin : g_lane
    localparam int D = DIM - c;
    logic [31:0] sr [D];
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        for (int i = 0; i < D; i++) sr[i] <= '0;
      end else if (shift_en) begin
        sr[0] <= acc_data_i[c];
        for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
      end
    end
    assign row_data_o[c] = sr[D-1];
  end

  assign acc_rd_en_o   = (state_q == SWEEP);
  assign acc_add_o     = 1'b0;
  assign acc_addr_rd_o = acc_rd_en_o ? (base_q + k_q[ADDR_W-1:0]) : '0;
  assign row_idx_o     = base_q + out_cnt_q;
  assign row_valid_o   = vld_q[DIM-1];
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;

endmodule

// File: tb/tb_accum_drain_ctrl.sv
// Scoreboard bench for accum_drain_ctrl: stimulus pushes expected rows, addresses
// and done pulses; a negedge monitor pops and compares them.
module tb_accum_drain_ctrl;
  localparam int DIM = 32;
  localparam int AW  = 7;

  logic                 clk_i = 1'b0;
  logic                 rst_i, start_i, row_ready_i;
  logic [AW-1:0]        base_addr_i, row_count_i;
  logic                 acc_rd_en_o, acc_add_o, row_valid_o, busy_o, done_o;
  logic [AW-1:0]        acc_addr_rd_o, row_idx_o;
  logic [DIM-1:0][31:0] acc_data_i, row_data_o;

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    int                   exp_cyc;
    logic [AW-1:0]        idx;
    logic                 last;
    logic [DIM-1:0][31:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            done_q[$];
  int            n_chk = 0, n_fail = 0, cyc = 0;
  bit            rand_ready = 1'b0;
  logic [31:0]   mem [128][DIM];

  accum_drain_ctrl #(.DIM(DIM), .ADDR_W(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .row_count_i(row_count_i),
    .acc_rd_en_o(acc_rd_en_o), .acc_add_o(acc_add_o), .acc_addr_rd_o(acc_addr_rd_o),
    .acc_data_i(acc_data_i), .row_data_o(row_data_o), .row_idx_o(row_idx_o),
    .row_valid_o(row_valid_o), .row_ready_i(row_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  // Skewed accumulator: lane c returns row (addr - c), column c.
  always_comb begin
    logic [AW-1:0] ra;
    acc_data_i = '0;
    ra = '0;
    for (int c = 0; c < DIM; c++) begin
      ra = acc_addr_rd_o - AW'(c);
      acc_data_i[c] = mem[ra][c];
    end
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic fill_mem(input bit pattern);
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < DIM; c++)
        mem[r][c] = pattern ? 32'(r * 256 + c) : $urandom;
  endtask

  task automatic flush();
    exp_q.delete();
    addr_q.delete();
    done_q.delete();
  endtask

  // Reference: rows base..base+n-1 in order, lane c = mem[row][c]; addresses
  // base+k for k in 0..n+DIM-2; unstalled row j lands DIM cycles after entry.
  task automatic issue(input logic [AW-1:0] b, input logic [AW-1:0] n, input bit timed);
    exp_t e;
    int   c0;
    c0 = cyc;
    base_addr_i = b;
    row_count_i = n;
    start_i     = 1'b1;
    for (int j = 0; j < int'(n); j++) begin
      e.exp_cyc = timed ? (c0 + 1 + j + DIM) : -1;
      e.idx     = b + AW'(j);
      e.last    = (j == int'(n) - 1);
      for (int c = 0; c < DIM; c++) e.data[c] = mem[e.idx][c];
      exp_q.push_back(e);
    end
    if (n != 0)
      for (int k = 0; k < int'(n) + DIM - 1; k++) addr_q.push_back(b + AW'(k));
    else
      done_q.push_back(c0 + 1);
    step(1);
    start_i     = 1'b0;
    base_addr_i = AW'($urandom);
    row_count_i = AW'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0 || done_q.size() != 0) && t < budget) begin
      step(1);
      t++;
    end
    if (t >= budget) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d rows %0d addrs %0d dones outstanding", exp_q.size(), addr_q.size(), done_q.size());
      flush();
    end
    step(2);
  endtask

  task automatic check_zero(input string pre);
    check({pre, "_rd_en"}, acc_rd_en_o, 0);
    check({pre, "_add"}, acc_add_o, 0);
    check({pre, "_addr"}, acc_addr_rd_o, 0);
    check({pre, "_valid"}, row_valid_o, 0);
    check({pre, "_data_zero"}, (row_data_o === '0), 1);
    check({pre, "_idx"}, row_idx_o, 0);
    check({pre, "_busy"}, busy_o, 0);
    check({pre, "_done"}, done_o, 0);
  endtask

  initial begin : monitor
    exp_t                 e;
    bit                   stall_p, adv, ed;
    logic [DIM-1:0][31:0] pd;
    logic [AW-1:0]        pi;
    int                   bad;
    stall_p = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        stall_p = 1'b0;
      end else begin
        adv = !(row_valid_o && !row_ready_i);
        check("add_sel", acc_add_o, 0);
        if (acc_rd_en_o) begin
          if (addr_q.size() == 0) check("rd_en_unexpected", acc_rd_en_o, 0);
          else begin
            check("rd_addr", acc_addr_rd_o, addr_q[0]);
            if (adv) void'(addr_q.pop_front());
          end
        end else if (!busy_o) begin
          check("idle_addr", acc_addr_rd_o, 0);
        end
        if (stall_p) begin
          check("stall_valid", row_valid_o, 1);
          check("stall_idx", row_idx_o, pi);
          check("stall_data", (row_data_o === pd), 1);
        end
        stall_p = row_valid_o && !row_ready_i;
        pd = row_data_o;
        pi = row_idx_o;
        if (row_valid_o) check("busy_with_row", busy_o, 1);
        if (row_valid_o && row_ready_i) begin
          if (exp_q.size() == 0) check("row_unexpected", row_valid_o, 0);
          else begin
            e = exp_q.pop_front();
            check("row_idx", row_idx_o, e.idx);
            bad = -1;
            for (int c = DIM - 1; c >= 0; c--) if (row_data_o[c] !== e.data[c]) bad = c;
            if (bad < 0) check("row_data", row_data_o[0], e.data[0]);
            else check($sformatf("row_data_lane%0d", bad), row_data_o[bad], e.data[bad]);
            if (e.exp_cyc >= 0) check("row_cycle", cyc, e.exp_cyc);
            if (e.last) done_q.push_back(cyc + 1);
          end
        end
        ed = (done_q.size() != 0 && done_q[0] == cyc);
        if (ed) void'(done_q.pop_front());
        if (ed || done_o) begin
          check("done", done_o, ed);
          if (done_o) check("busy_at_done", busy_o, 0);
        end
      end
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk_i);
      #1;
      if (rand_ready) row_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [AW-1:0] b;
    int            t;
    rst_i = 1'b0; start_i = 1'b0; base_addr_i = '0; row_count_i = '0; row_ready_i = 1'b1;
    fill_mem(1'b1);
    step(3);
    check_zero("reset");
    rst_i = 1'b1;
    step(2);

    issue(7'd0, 7'd4, 1'b1);
    wait_idle(200);

    issue(7'd126, 7'd4, 1'b1);
    wait_idle(200);

    issue(AW'($urandom), 7'd0, 1'b1);
    wait_idle(20);

    fill_mem(1'b0);
    b = AW'($urandom);
    issue(b, 7'd3, 1'b0);
    t = 0;
    while (!(row_valid_o && row_idx_o == b + AW'(1)) && t < 100) begin
      step(1);
      t++;
    end
    if (t >= 100) begin
      n_chk++; n_fail++;
      $display("FAIL stall_setup: row 1 never presented");
    end
    row_ready_i = 1'b0;
    step(5);
    row_ready_i = 1'b1;
    wait_idle(200);

    b = AW'($urandom);
    issue(b, 7'd20, 1'b0);
    step(10);
    start_i = 1'b1; base_addr_i = b + AW'(50); row_count_i = 7'd7;
    step(1);
    start_i = 1'b0;
    wait_idle(300);

    b = AW'($urandom);
    issue(b, 7'd10, 1'b0);
    t = 0;
    while (!(acc_rd_en_o && acc_addr_rd_o == b + AW'(20)) && t < 100) begin
      step(1);
      t++;
    end
    if (t >= 100) begin
      n_chk++; n_fail++;
      $display("FAIL abort_setup: k=20 never reached");
    end
    rst_i = 1'b0;
    flush();
    #1;
    check_zero("abort");
    step(3);
    rst_i = 1'b1;
    step(2);
    issue(7'd5, 7'd2, 1'b1);
    wait_idle(200);

    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fill_mem(1'b0);
      issue(AW'($urandom), (i == 5) ? 7'd0 : AW'($urandom_range(1, 97)), 1'b0);
      wait_idle(3000);
    end
    rand_ready = 1'b0;
    step(1);
    row_ready_i = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
